sc_point_position_register: RTL
===============================

# sc_point_position_register

Holds the frog's position on the playfield matrix and applies the movement commands issued by the point state machine each cycle. The block sits directly downstream of that state machine and consumes its active-low `clear`, `load0` (up) and `load1` (down) strobes and its 2-bit shift selection. It drives the flattened point matrix to the display and collision logic. It also returns the bottom-side comparator flag that the state machine uses to gate downward moves.

## Interface
Parameters:
- ROWS, 8: number of playfield rows; row 0 is the top (goal) row and row ROWS-1 is the bottom (start) row.
- COLS, 8: number of columns; the column is held one-hot, with bit COLS-1 as the leftmost column.
- INIT_COL, 3: column index loaded on reset or clear.

Ports:
- SC_STATEMACHINEPOINT_CLOCK_50, in, 1: system clock; every register updates on its rising edge.
- SC_STATEMACHINEPOINT_RESET_InHigh, in, 1: reset, asynchronous, active-high.
- SC_POINTREGISTER_clear_InLow, in, 1: when 0, return to the start position.
- SC_POINTREGISTER_load0_InLow, in, 1: when 0, move up one row.
- SC_POINTREGISTER_load1_InLow, in, 1: when 0, move down one row.
- SC_POINTREGISTER_shiftselection_In, in, 2: 01 moves left, 10 moves right, 11 and 00 hold.
- SC_POINTREGISTER_row_Out, out, clog2(ROWS): current row index.
- SC_POINTREGISTER_col_Out, out, COLS: current column, one-hot.
- SC_POINTREGISTER_matrix_Out, out, ROWS*COLS: the point matrix; slice [r*COLS +: COLS] equals col_Out when r==row_Out and 0 otherwise.
- SC_POINTREGISTER_bottomsidecomparator_OutLow, out, 1: 0 when row_Out==ROWS-1, otherwise 1.
- SC_POINTREGISTER_topReached_Out, out, 1: one-cycle pulse when a move lands on row 0.
- SC_POINTREGISTER_moves_Out, out, 8: count of accepted moves, saturating at 255.

## Operation
- Reset (asynchronous): row = ROWS-1; col = 1<<INIT_COL; moves = 0; topReached = 0; bottomsidecomparator_OutLow = 0.
- Command priority, evaluated once per cycle:
  1. clear
  2. load0
  3. load1
  4. shiftselection
- At most one action is applied per cycle. Lower-priority commands asserted in the same cycle are ignored.
- clear=0: row = ROWS-1; col = 1<<INIT_COL; moves = 0. The move is not counted and topReached is not asserted.
- load0=0 with row>0: row decrements. If the new row is 0, topReached is set to 1 for exactly the next cycle.
- load0=0 with row==0: hold. No pulse and no count.
- load1=0 with row<ROWS-1: row increments.
- load1=0 with row==ROWS-1: hold and do not count. The state machine normally masks this case; it is still required to be safe.
- shift 01: col shifts left by one. If col[COLS-1] is already 1, hold; there is no wrap.
- shift 10: col shifts right by one. If col[0] is already 1, hold; there is no wrap.
- shift 00 or 11: hold.
- A move is accepted only if row or col actually changes. Each accepted move increments moves, saturating at 255.
- col is always exactly one-hot. No command sequence can produce zero bits or multiple bits set.
- topReached defaults to 0 every cycle unless set by the load0 rule above.

## Timing
- Inputs are sampled on the rising edge. The upstream strobes are one clock wide because each is one state-machine state.
- row, col and moves are registered and update on the edge that samples the command. Each is visible one cycle after the strobe.
- matrix_Out and bottomsidecomparator_OutLow are combinational from the row and col registers, so they share the same latency and have no additional delay.
- topReached_Out is registered. It goes high on the same edge that writes row=0 and is low on the following edge.
- Reset asserted mid-move overrides everything immediately. Deasserting reset does not replay any pending command.
- Continuous strobes (never generated upstream, because CHECK_1 waits for release): one move is applied per cycle, with saturation at the edges.

## Test plan
- Reset check: after reset, expect row=7, col=0x08, bottomsidecomparator_OutLow=0, moves=0, and matrix bits [63:56]=0x08 with all other bits 0.
- Climb to the top: apply seven load0 pulses. Expect row 6 through 0, bottomsidecomparator_OutLow=1 after the first pulse, and topReached high only in the cycle after the seventh pulse. Expect moves=7. An eighth pulse gives row=0, no pulse, moves=7.
- Left saturation: apply five shift=01 pulses from reset. Expect col 0x10, 0x20, 0x40, 0x80, 0x80 and moves=4.
- Right saturation: apply four shift=10 pulses from reset. Expect col 0x04, 0x02, 0x01, 0x01.
- Simultaneous commands: assert load0=0 together with shift=01. Expect only the row to change. Assert clear=0 together with load0=0 at row 3. Expect row=7, col=0x08, moves=0, and no topReached pulse.
- Bottom guard and reset: apply load1=0 at row 7 and expect no change. Then assert asynchronous reset mid-cycle at row 2. Expect the outputs to return to their reset values before the next clock edge.

Source files
------------

// File: rtl/sc_point_position_register.sv
// Frog position register: holds the row index and one-hot column of the point,
// applies the prioritised move strobes from the point state machine and drives the matrix.
module sc_point_position_register #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int INIT_COL = 3
) (
  input  logic                      SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic                      SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic                      SC_POINTREGISTER_clear_InLow,
  input  logic                      SC_POINTREGISTER_load0_InLow,
  input  logic                      SC_POINTREGISTER_load1_InLow,
  input  logic [1:0]                SC_POINTREGISTER_shiftselection_In,
  output logic [$clog2(ROWS)-1:0]   SC_POINTREGISTER_row_Out,
  output logic [COLS-1:0]           SC_POINTREGISTER_col_Out,
  output logic [ROWS*COLS-1:0]      SC_POINTREGISTER_matrix_Out,
  output logic                      SC_POINTREGISTER_bottomsidecomparator_OutLow,
  output logic                      SC_POINTREGISTER_topReached_Out,
  output logic [7:0]                SC_POINTREGISTER_moves_Out
);

  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0] BOTTOM_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] TOP_ROW     = '0;
  localparam logic [ROW_W-1:0] ONE_ROW     = ROW_W'(1);
  localparam logic [COLS-1:0]  INIT_ONEHOT = COLS'(1) << INIT_COL;
  localparam logic [7:0]       MOVES_MAX   = 8'hFF;

  logic [ROW_W-1:0] rowReg, rowNext;
  logic [COLS-1:0]  colReg, colNext;
  logic [7:0]       movesReg, movesNext;
  logic             topReg, topNext;
  logic             moveAccepted;

  // Only the highest-priority asserted strobe is considered; if it cannot move
  // (edge of the playfield) the cycle is a hold and lower strobes are dropped.
  always_comb begin
    rowNext      = rowReg;
    colNext      = colReg;
    topNext      = 1'b0;
    moveAccepted = 1'b0;
    if (!SC_POINTREGISTER_clear_InLow) begin
      rowNext = BOTTOM_ROW;
      colNext = INIT_ONEHOT;
    end else if (!SC_POINTREGISTER_load0_InLow) begin
      if (rowReg != TOP_ROW) begin
        rowNext      = rowReg - ONE_ROW;
        moveAccepted = 1'b1;
        topNext      = (rowReg == ONE_ROW);
      end
    end else if (!SC_POINTREGISTER_load1_InLow) begin
      if (rowReg != BOTTOM_ROW) begin
        rowNext      = rowReg + ONE_ROW;
        moveAccepted = 1'b1;
      end
    end else begin
      case (SC_POINTREGISTER_shiftselection_In)
        2'b01: begin
          if (!colReg[COLS-1]) begin
            colNext      = colReg << 1;
            moveAccepted = 1'b1;
          end
        end
        2'b10: begin
          if (!colReg[0]) begin
            colNext      = colReg >> 1;
            moveAccepted = 1'b1;
          end
        end
        default: begin
          colNext = colReg;
        end
      endcase
    end
  end

  always_comb begin
    movesNext = movesReg;
    if (!SC_POINTREGISTER_clear_InLow) begin
      movesNext = '0;
    end else if (moveAccepted && (movesReg != MOVES_MAX)) begin
      movesNext = movesReg + 8'd1;
    end
  end

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      rowReg   <= BOTTOM_ROW;
      colReg   <= INIT_ONEHOT;
      movesReg <= '0;
      topReg   <= 1'b0;
    end else begin
      rowReg   <= rowNext;
      colReg   <= colNext;
      movesReg <= movesNext;
      topReg   <= topNext;
    end
  end

  // Matrix and bottom flag are decoded straight from the registers, no extra stage.
  for (genvar r = 0; r < ROWS; r++) begin : genMatrixRow
    assign SC_POINTREGISTER_matrix_Out[r*COLS +: COLS] =
      (rowReg == ROW_W'(r)) ? colReg : '0;
  end

  assign SC_POINTREGISTER_row_Out                     = rowReg;
  assign SC_POINTREGISTER_col_Out                     = colReg;
  assign SC_POINTREGISTER_moves_Out                   = movesReg;
  assign SC_POINTREGISTER_topReached_Out              = topReg;
  assign SC_POINTREGISTER_bottomsidecomparator_OutLow = (rowReg != BOTTOM_ROW);

endmodule
